// File: rtl/sync_debounce_edge_if.sv
// rtl/sync_debounce_edge_if.sv - signal bundle between the debounce stage and its consumer
interface sync_debounce_edge_if #(
    parameter int CNT_W = 8
);
    logic             data_i;
    logic [CNT_W-1:0] thr_i;
    logic             clr_i;
    logic             level_o;
    logic             rise_o;
    logic             fall_o;
    logic             busy_o;

    modport master (
        output data_i, thr_i, clr_i,
        input  level_o, rise_o, fall_o, busy_o
    );

    modport slave (
        input  data_i, thr_i, clr_i,
        output level_o, rise_o, fall_o, busy_o
    );
endinterface

// File: rtl/sync_debounce_edge.sv
// rtl/sync_debounce_edge.sv - consecutive-sample debounce filter with rise/fall pulses
module sync_debounce_edge #(
    parameter int   CNT_W   = 8,
    parameter logic RST_LVL = 1'b0
) (
    input logic                 clki,
    input logic                 rstn,
    sync_debounce_edge_if.slave dbif
);
    typedef enum logic {ST_STABLE, ST_COUNT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    logic [CNT_W-1:0] thr_eff;
    logic [CNT_W:0]   cnt_inc;
    logic             mismatch;

    // A zero threshold behaves like one; the extra bit keeps cnt+1 from wrapping in the compare
    assign thr_eff  = (dbif.thr_i == '0) ? CNT_W'(1) : dbif.thr_i;
    assign cnt_inc  = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign mismatch = (dbif.data_i != level_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (dbif.clr_i) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
            level_d = RST_LVL;
        end else begin
            case (state_q)
                ST_STABLE: begin
                    if (mismatch) begin
                        if (thr_eff == CNT_W'(1)) begin
                            level_d = ~level_q;
                            rise_d  = ~level_q;
                            fall_d  = level_q;
                        end else begin
                            state_d = ST_COUNT;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                ST_COUNT: begin
                    if (!mismatch) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_inc >= {1'b0, thr_eff}) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                        level_d = ~level_q;
                        rise_d  = ~level_q;
                        fall_d  = level_q;
                    end else begin
                        cnt_d = cnt_inc[CNT_W-1:0];
                    end
                end
                default: begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clki or posedge rstn) begin
        if (rstn) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            level_q <= RST_LVL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign dbif.level_o = level_q;
    assign dbif.rise_o  = rise_q;
    assign dbif.fall_o  = fall_q;
    assign dbif.busy_o  = (state_q == ST_COUNT);
endmodule

// File: tb/tb_sync_debounce_edge.sv
// tb/tb_sync_debounce_edge.sv - scoreboard bench for sync_debounce_edge
module tb_sync_debounce_edge;
    localparam int CNT_W = 8;

    typedef struct {
        logic  l;
        logic  r;
        logic  f;
        logic  b;
        string name;
    } exp_t;

    logic clki = 1'b0;
    logic rstn = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    sync_debounce_edge_if #(.CNT_W(CNT_W)) dbif ();

    sync_debounce_edge #(.CNT_W(CNT_W), .RST_LVL(1'b0)) dut (
        .clki (clki),
        .rstn (rstn),
        .dbif (dbif.slave)
    );

    always #5 clki = ~clki;

    // Monitor: every clock the DUT presents a registered output vector; pop and compare
    always @(posedge clki) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if ({dbif.level_o, dbif.rise_o, dbif.fall_o, dbif.busy_o} !== {e.l, e.r, e.f, e.b}) begin
                errors++;
                $display("FAIL %s: got level=%b rise=%b fall=%b busy=%b, want level=%b rise=%b fall=%b busy=%b",
                         e.name, dbif.level_o, dbif.rise_o, dbif.fall_o, dbif.busy_o, e.l, e.r, e.f, e.b);
            end
            checks++;
            if (dbif.rise_o && dbif.fall_o) begin
                errors++;
                $display("FAIL %s_both_pulses: got rise=1 fall=1, want not both", e.name);
            end
        end
    end

    task automatic cyc(input logic r, input logic d, input logic [CNT_W-1:0] t, input logic c,
                       input logic el, input logic er, input logic ef, input logic eb,
                       input string nm);
        exp_t e;
        @(negedge clki);
        rstn        = r;
        dbif.data_i = d;
        dbif.thr_i  = t;
        dbif.clr_i  = c;
        e.l = el; e.r = er; e.f = ef; e.b = eb; e.name = nm;
        sb_q.push_back(e);
    endtask

    // Hold d for T samples starting from level ~d: busy for T-1, then flip with pulse
    task automatic run(input logic d, input logic [CNT_W-1:0] t, input int T, input string nm);
        for (int i = 1; i < T; i++) cyc(1'b0, d, t, 1'b0, ~d, 1'b0, 1'b0, 1'b1, nm);
        cyc(1'b0, d, t, 1'b0, d, d, ~d, 1'b0, nm);
    endtask

    initial begin
        dbif.data_i = 1'b1;
        dbif.thr_i  = 8'd4;
        dbif.clr_i  = 1'b0;

        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
        run(1'b1, 8'd4, 4, "rst_release");
        cyc(1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "hold_high");

        run(1'b0, 8'd4, 4, "step_fall");
        cyc(1'b0, 1'b0, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "hold_low");
        run(1'b1, 8'd4, 4, "step_rise");
        run(1'b0, 8'd4, 4, "step_fall2");

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "glitch_cnt");
        cyc(1'b0, 1'b0, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "glitch_back");
        cyc(1'b0, 1'b0, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "glitch_idle");

        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "thr0_rise");
            cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "thr0_fall");
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "thr1_rise");
            cyc(1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "thr1_fall");
        end

        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "thr_lower_cnt");
        cyc(1'b0, 1'b1, 8'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "thr_lower_flip");
        cyc(1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "thr_lower_back");

        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "thr_raise_cnt3");
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "thr_raise_cnt10");
        cyc(1'b0, 1'b1, 8'd10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "thr_raise_flip");
        cyc(1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "thr_raise_back");

        for (int i = 1; i < 200; i++) cyc(1'b0, 1'b1, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "max_pre_clr");
        cyc(1'b0, 1'b1, 8'd255, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "clr_mid_count");
        run(1'b1, 8'd255, 255, "max_count");

        cyc(1'b0, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "clr_from_high");
        cyc(1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "after_clr");

        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rst_mid_cnt");
        cyc(1'b1, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_mid_hold");
        cyc(1'b0, 1'b0, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_mid_after");
        cyc(1'b0, 1'b0, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_mid_idle");

        repeat (3) @(posedge clki);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
